instruction_fetch_stage: RTL and testbench

- IF stage of the 5-stage pipelined MIPS core: owns the PC, drives the combinational instruction memory address, and captures the returned word into the IF/ID pipeline register.
- Next-PC selection covers sequential, branch, jump and jr targets resolved in ID; stall and flush come from the hazard unit.
- Downstream consumer is the ID stage (decoder/register file).

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/instruction_fetch_stage_ifid_reg.sv | 57 +++++
 rtl/instruction_fetch_stage.sv | 116 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared encodings, constants and helpers for the IF stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Next-PC source selection driven by the ID stage
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_JR     = 2'd3;

  // All-zero word decodes as sll $0,$0,0, i.e. a nop
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default reset and trap entry addresses
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0008;

  // Instruction fetches are word aligned; drop the byte offset of a target
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register with flush-over-stall priority, a
//               valid bit marking bubbles, and a committed-fetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        bubble,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        valid,
  output logic [31:0] fetch_count
);

  logic w_squash;
  logic w_write;

  // A trap-forced bubble squashes exactly like a hazard-unit flush
  assign w_squash = flush | bubble;
  assign w_write  = ~w_squash & ~stall;

  // Pipeline register: squash beats stall, stall holds, otherwise capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_plus4 <= 32'h0;
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (w_squash) begin
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (w_write) begin
      pc_plus4 <= pc_plus4_in;
      instr    <= instr_in;
      valid    <= 1'b1;
    end
  end

  // Count only edges that commit a real instruction; wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
    end else if (w_write) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : IF stage of the 5-stage MIPS pipeline. Owns the PC and the
//               next-PC mux, drives the instruction memory address, and
//               feeds the IF/ID register.
//               Optional macro FETCH_EXCEPTION_EN adds irq/exception entry.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
`ifdef FETCH_EXCEPTION_EN
  ,
  parameter logic [31:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic [31:0] fetch_count_o
`ifdef FETCH_EXCEPTION_EN
  ,
  input  logic        irq_i,
  input  logic        exc_i,
  output logic [31:0] ifid_epc_o
`endif
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_trap;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign imem_addr_o = r_pc;

`ifdef FETCH_EXCEPTION_EN
  logic w_irq_taken;

  // Interrupts are masked while executing in kernel space (pc[31]=1)
  assign w_irq_taken = irq_i & ~r_pc[31];
  assign w_trap      = exc_i | w_irq_taken;
`else
  assign w_trap = 1'b0;
`endif

  // Next-PC mux: trap, then ID redirect (even under stall), then hold, then +4
  always_comb begin
    w_next_pc = w_pc_plus4;
`ifdef FETCH_EXCEPTION_EN
    if (exc_i) begin
      w_next_pc = word_align(EXC_VECTOR);
    end else if (w_irq_taken) begin
      w_next_pc = word_align(IRQ_VECTOR);
    end else
`endif
    if (pc_src_i != PC_SRC_SEQ) begin
      case (pc_src_i)
        PC_SRC_BRANCH: w_next_pc = word_align(branch_target_i);
        PC_SRC_JUMP:   w_next_pc = word_align(jump_target_i);
        default:       w_next_pc = word_align(jr_target_i);
      endcase
    end else if (stall_i) begin
      w_next_pc = r_pc;
    end
  end

  // Program counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

`ifdef FETCH_EXCEPTION_EN
  // Record the PC that was interrupted so the handler can return to it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_epc_o <= 32'h0;
    end else if (w_trap) begin
      ifid_epc_o <= r_pc;
    end
  end
`endif

  ifid_reg u_ifid_reg (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_i),
    .stall       (stall_i),
    .bubble      (w_trap),
    .pc_plus4_in (w_pc_plus4),
    .instr_in    (imem_instr_i),
    .pc_plus4    (ifid_pc_plus4_o),
    .instr       (ifid_instr_o),
    .valid       (ifid_valid_o),
    .fetch_count (fetch_count_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic [1:0]  pc_src_i;
  logic [31:0] branch_target_i;
  logic [31:0] jump_target_i;
  logic [31:0] jr_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic [31:0] fetch_count_o;
`ifdef FETCH_EXCEPTION_EN
  logic        irq_i;
  logic        exc_i;
  logic [31:0] ifid_epc_o;
`endif

  int n_checks;
  int n_errors;

  instruction_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .pc_src_i        (pc_src_i),
    .branch_target_i (branch_target_i),
    .jump_target_i   (jump_target_i),
    .jr_target_i     (jr_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_instr_i    (imem_instr_i),
    .ifid_pc_plus4_o (ifid_pc_plus4_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_valid_o    (ifid_valid_o),
    .fetch_count_o   (fetch_count_o)
`ifdef FETCH_EXCEPTION_EN
    ,
    .irq_i           (irq_i),
    .exc_i           (exc_i),
    .ifid_epc_o      (ifid_epc_o)
`endif
  );

  // Instruction memory model: one known word at the reset PC, else ~addr
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h3c01_4000 : ~a;
  endfunction

  assign imem_instr_i = imem_word(imem_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    pc_src_i = 2'd0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc4,
                            input logic [31:0] ins, input logic v, input logic [31:0] cnt);
    check({tag, "_pc4"},   ifid_pc_plus4_o, pc4);
    check({tag, "_instr"}, ifid_instr_o,    ins);
    check({tag, "_valid"}, {31'h0, ifid_valid_o}, {31'h0, v});
    check({tag, "_count"}, fetch_count_o,   cnt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    idle_inputs();
    branch_target_i = 32'h0;
    jump_target_i   = 32'h0;
    jr_target_i     = 32'h0;
`ifdef FETCH_EXCEPTION_EN
    irq_i = 1'b0;
    exc_i = 1'b0;
`endif
    #12;
    check("rst_addr", imem_addr_o, 32'h0040_0000);
    check_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);

    // Release reset between edges
    reset = 1'b0;
    #1;
    check("rel_addr", imem_addr_o, 32'h0040_0000);

    step();
    check("e1_addr", imem_addr_o, 32'h0040_0004);
    check_ifid("e1", 32'h0040_0004, 32'h3c01_4000, 1'b1, 32'd1);
    step();
    check("e2_addr", imem_addr_o, 32'h0040_0008);
    check("e2_count", fetch_count_o, 32'd2);
    step(); step(); step();
    check("seq_addr", imem_addr_o, 32'h0040_0014);
    check_ifid("seq", 32'h0040_0014, ~32'h0040_0010, 1'b1, 32'd5);

    // Two stalled edges: PC and IF/ID hold
    stall_i = 1'b1;
    step(); step();
    check("stall_addr", imem_addr_o, 32'h0040_0014);
    check_ifid("stall", 32'h0040_0014, ~32'h0040_0010, 1'b1, 32'd5);
    stall_i = 1'b0;
    step();
    check("resume_addr", imem_addr_o, 32'h0040_0018);
    check_ifid("resume", 32'h0040_0018, ~32'h0040_0014, 1'b1, 32'd6);

    // Jump with flush: redirect, bubble, no count
    pc_src_i = 2'd2; jump_target_i = 32'h0040_0044; flush_i = 1'b1;
    step();
    idle_inputs();
    check("jump_addr", imem_addr_o, 32'h0040_0044);
    check_ifid("jump", 32'h0040_0018, 32'h0, 1'b0, 32'd6);

    // jr under stall: redirect wins, low bits dropped, IF/ID holds
    pc_src_i = 2'd3; jr_target_i = 32'h0040_001F; stall_i = 1'b1;
    step();
    idle_inputs();
    check("jr_addr", imem_addr_o, 32'h0040_001C);
    check_ifid("jr", 32'h0040_0018, 32'h0, 1'b0, 32'd6);

    // Branch to top of memory (no flush), then sequential wrap
    pc_src_i = 2'd1; branch_target_i = 32'hFFFF_FFFE;
    step();
    idle_inputs();
    check("br_addr", imem_addr_o, 32'hFFFF_FFFC);
    check_ifid("br", 32'h0040_0020, ~32'h0040_001C, 1'b1, 32'd7);
    step();
    check("wrap_addr", imem_addr_o, 32'h0000_0000);
    check_ifid("wrap", 32'h0000_0000, 32'h0000_0003, 1'b1, 32'd8);

    // Go to 0x00400100, then reset asynchronously mid-cycle
    pc_src_i = 2'd2; jump_target_i = 32'h0040_0100;
    step();
    idle_inputs();
    check("pre_rst_addr", imem_addr_o, 32'h0040_0100);
    #2;
    reset = 1'b1;
    #1;
    check("async_addr", imem_addr_o, 32'h0040_0000);
    check_ifid("async", 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    reset = 1'b0;
    step();
    check("restart_addr", imem_addr_o, 32'h0040_0004);
    check_ifid("restart", 32'h0040_0004, 32'h3c01_4000, 1'b1, 32'd1);

`ifdef FETCH_EXCEPTION_EN
    pc_src_i = 2'd2; jump_target_i = 32'h0040_0020;
    step();
    idle_inputs();
    exc_i = 1'b1;
    step();
    exc_i = 1'b0;
    check("exc_addr", imem_addr_o, 32'h8000_0008);
    check("exc_epc", ifid_epc_o, 32'h0040_0020);
    check("exc_valid", {31'h0, ifid_valid_o}, 32'h0);
    // Kernel mode: interrupt ignored, sequential fetch continues
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    check("irq_masked_addr", imem_addr_o, 32'h8000_000C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
